// File: rtl/frame_flusher_pkg.sv
// rtl/frame_flusher_pkg.sv - shared screen geometry, colour width and flusher state encoding
package frame_flusher_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int COLOUR_W = 6;
    localparam logic [COLOUR_W-1:0] BG_COLOUR = 6'h00;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/frame_flusher_raster_counter.sv
// rtl/frame_flusher_raster_counter.sv - x/y raster counter with enable, clear and last-pixel flag
module raster_counter #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       clr,
    input  logic       en,
    output logic [7:0] x,
    output logic [7:0] y,
    output logic       last
);

    localparam logic [7:0] X_LAST = 8'(SCREEN_W - 1);
    localparam logic [7:0] Y_LAST = 8'(SCREEN_H - 1);

    logic x_last;

    assign x_last = (x == X_LAST);
    assign last   = x_last && (y == Y_LAST);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            x <= 8'd0;
            y <= 8'd0;
        end else if (clr) begin
            x <= 8'd0;
            y <= 8'd0;
        end else if (en) begin
            if (x_last) begin
                x <= 8'd0;
                y <= y + 8'd1;
            end else begin
                x <= x + 8'd1;
            end
        end
    end

endmodule

// File: rtl/frame_flusher.sv
// rtl/frame_flusher.sv - sweeps one frame of coordinates through the decoders into vga_adapter writes
module frame_flusher #(
    parameter int SCREEN_W = frame_flusher_pkg::SCREEN_W,
    parameter int SCREEN_H = frame_flusher_pkg::SCREEN_H,
    parameter logic [frame_flusher_pkg::COLOUR_W-1:0] BG_COLOUR = frame_flusher_pkg::BG_COLOUR
) (
    input  logic                                   clk,
    input  logic                                   resetn,
    input  logic                                   start,
    input  logic                                   pause,
    output logic [7:0]                             flush_x,
    output logic [7:0]                             flush_y,
    input  logic [frame_flusher_pkg::COLOUR_W-1:0] pix_colour,
    input  logic                                   pix_enable,
    output logic [7:0]                             vga_x,
    output logic [7:0]                             vga_y,
    output logic [frame_flusher_pkg::COLOUR_W-1:0] vga_colour,
    output logic                                   vga_plot,
    output logic                                   busy,
    output logic                                   done
);

    import frame_flusher_pkg::*;

    state_t state, state_nxt;
    logic   last;
    logic   capture;
    logic   scan_en;
    logic   cnt_clr;

    // A paused cycle neither captures nor advances, so the held pixel is written once on resume.
    assign capture = (state == ST_SCAN) && !pause;
    assign scan_en = capture && !last;
    assign cnt_clr = (state != ST_SCAN);
    assign busy    = (state != ST_IDLE);

    raster_counter #(
        .SCREEN_W (SCREEN_W),
        .SCREEN_H (SCREEN_H)
    ) u_raster_counter (
        .clk    (clk),
        .resetn (resetn),
        .clr    (cnt_clr),
        .en     (scan_en),
        .x      (flush_x),
        .y      (flush_y),
        .last   (last)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_SCAN;
            ST_SCAN:  if (capture && last) state_nxt = ST_DRAIN;
            ST_DRAIN: state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vga_x      <= 8'd0;
            vga_y      <= 8'd0;
            vga_colour <= '0;
            vga_plot   <= 1'b0;
            done       <= 1'b0;
        end else begin
            vga_plot <= capture;
            done     <= (state == ST_DRAIN);
            if (capture) begin
                vga_x      <= flush_x;
                vga_y      <= flush_y;
                vga_colour <= pix_enable ? pix_colour : BG_COLOUR;
            end
        end
    end

endmodule

// File: tb/tb_frame_flusher.sv
// tb/tb_frame_flusher.sv - self-checking bench for frame_flusher with a raster-order plot model
`timescale 1ns/1ps
module tb_frame_flusher;

    localparam int W = 160;
    localparam int H = 120;
    localparam int N = W * H;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic [7:0] flush_x, flush_y, vga_x, vga_y;
    logic [5:0] pix_colour, vga_colour;
    logic       pix_enable, vga_plot, busy, done;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int t_start = 0;
    int p = 0;
    int done_count = 0;
    int glyph_hits = 0;
    int exp_latency = N + 1;
    logic pause_q = 1'b0;

    frame_flusher dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .pause      (pause),
        .flush_x    (flush_x),
        .flush_y    (flush_y),
        .pix_colour (pix_colour),
        .pix_enable (pix_enable),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    function automatic logic glyph_at(input int x, input int y);
        return (x == 15 && y == 20) || (x == 16 && y == 21);
    endfunction

    // Decoder stand-in: colour 2A when not enabled must never reach the VGA side.
    always_comb begin
        pix_enable = glyph_at(int'(flush_x), int'(flush_y));
        pix_colour = pix_enable ? 6'h3F : 6'h2A;
    end

    function automatic int outs_active();
        return ({vga_x, vga_y, vga_colour, vga_plot, busy, done, flush_x, flush_y} != '0) ? 1 : 0;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        pause_q <= pause;
        if (resetn && start && !busy) t_start <= cyc + 1;
    end

    // Model: plots must arrive in raster order, one per pixel, and done closes the frame.
    always @(negedge clk) begin
        if (!resetn) begin
            check("reset_outputs", outs_active(), 0);
            p = 0;
        end else begin
            if (vga_plot) begin
                check("plot_while_paused", int'(pause_q), 0);
                check("plot_busy", int'(busy), 1);
                check("plot_pixel", int'({vga_x, vga_y, vga_colour}),
                      int'({8'(p % W), 8'(p / W), glyph_at(p % W, p / W) ? 6'h3F : 6'h00}));
                if (vga_colour == 6'h3F) glyph_hits++;
                p++;
            end
            if (done) begin
                done_count++;
                check("done_pixel_count", p, N);
                check("done_latency", cyc - t_start, exp_latency);
                check("done_busy", int'(busy), 0);
                p = 0;
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #2;
        end
    endtask

    task automatic wait_flush(input int x, input int y, input string name);
        int k = 0;
        while (!(int'(flush_x) == x && int'(flush_y) == y) && k < N + 100) begin
            step();
            k++;
        end
        check(name, int'(k < N + 100), 1);
    endtask

    task automatic wait_done(input string name);
        int k = 0;
        while (!done && k < N + 100) begin
            step();
            k++;
        end
        check(name, int'(k < N + 100), 1);
    endtask

    task automatic wait_plot(input string name);
        int k = 0;
        while (!vga_plot && k < 20) begin
            step();
            k++;
        end
        check(name, int'(k < 20), 1);
    endtask

    initial begin
        resetn = 1'b0;
        step(3);
        check("reset_literal", outs_active(), 0);
        resetn = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step();
            check("idle_quiet", outs_active(), 0);
        end

        // Frame 1: glyphs, a 7-cycle pause at (100,5), and an ignored start at (50,50).
        exp_latency = N + 1 + 7;
        glyph_hits = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        check("busy_after_start", int'(busy), 1);
        wait_flush(100, 5, "reach_100_5");
        pause = 1'b1;
        step(7);
        pause = 1'b0;
        wait_plot("resume_plot");
        check("resume_pixel", int'({vga_x, vga_y}), int'({8'd100, 8'd5}));
        wait_flush(50, 50, "reach_50_50");
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done("frame1_done");
        check("frame1_glyph_hits", glyph_hits, 2);
        step(5);
        check("frame1_single_done", done_count, 1);
        check("frame1_idle_after", int'(busy), 0);

        // Frames 2/3: start held through done restarts immediately; frame 3 is reset mid-way.
        exp_latency = N + 1;
        start = 1'b1;
        wait_done("frame2_done");
        step();
        check("restart_busy", int'(busy), 1);
        check("restart_no_done", int'(done), 0);
        start = 1'b0;
        wait_flush(80, 60, "reach_80_60");
        resetn = 1'b0;
        #1;
        check("async_reset_outputs", outs_active(), 0);
        step(2);
        resetn = 1'b1;
        step(5);
        check("no_done_after_abort", done_count, 2);
        check("idle_after_abort", int'(busy), 0);

        // Frame 4: fresh scan from the origin.
        glyph_hits = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_plot("frame4_first_plot");
        check("frame4_origin", int'({vga_x, vga_y}), 0);
        wait_done("frame4_done");
        check("frame4_glyph_hits", glyph_hits, 2);
        check("total_dones", done_count, 3);
        step(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
